// File: rtl/spinnaker_fpgas_spi_reg_master.sv
// Purpose : SPI mode-0 slave that turns 56-bit serial frames into register-bank reads/writes.
// Latency : WRITE_OUT fires 2 cycles after the synchronised 56th SCLK rise (4 cycles from the pin).
// Backpr. : none; the SPI master paces the frame, the bank is combinational and always ready.
//
// Ports:
//   CLK_IN, RESET_IN      system clock (>= 8x SCLK), asynchronous active-high reset
//   SPI_NSS_IN            chip select, active low, asynchronous
//   SPI_SCLK_IN           SPI clock, idles low, asynchronous
//   SPI_MOSI_IN           serial data in, sampled on SCLK rise
//   SPI_MISO_OUT          serial read data out, updated on SCLK fall
//   WRITE_OUT             single-cycle register write strobe
//   ADDR_OUT              register address (low REGA_BITS of the 16-bit frame address)
//   WRITE_DATA_OUT        register write data
//   READ_DATA_IN          combinational read data for ADDR_OUT
//
// Frame layout, MSB first: cmd[7:0] (0x01 write, 0x00 read, else NOP),
// addr[15:0], data[31:0]. REGA_BITS must not exceed 16 and REGD_BITS must be 32.

module spinnaker_fpgas_spi_reg_master #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic                 SPI_NSS_IN,
  input  logic                 SPI_SCLK_IN,
  input  logic                 SPI_MOSI_IN,
  output logic                 SPI_MISO_OUT,
  output logic                 WRITE_OUT,
  output logic [REGA_BITS-1:0] ADDR_OUT,
  output logic [REGD_BITS-1:0] WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] READ_DATA_IN
);

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Idle values (NSS high, SCLK low, MOSI low) are used
  // as reset values so that reset never manufactures an edge on SCLK.
  // ---------------------------------------------------------------------------
  logic nss_meta_q,  nss_sync_q,  nss_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      nss_meta_q  <= 1'b1;
      nss_sync_q  <= 1'b1;
      nss_prev_q  <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      nss_meta_q  <= SPI_NSS_IN;
      nss_sync_q  <= nss_meta_q;
      nss_prev_q  <= nss_sync_q;
      sclk_meta_q <= SPI_SCLK_IN;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= SPI_MOSI_IN;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic nss_fall;
  logic sclk_rise;
  logic sclk_fall;

  assign nss_fall  = nss_prev_q & ~nss_sync_q;
  // Edges seen while NSS is (synchronised) high are never acted on; this also
  // keeps a rise that coincides with an abort from completing a frame.
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q & ~nss_sync_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q & ~nss_sync_q;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t                 state_q,     state_d;
  logic [4:0]             bit_cnt_q,   bit_cnt_d;
  logic [30:0]            shift_in_q,  shift_in_d;
  logic [7:0]             cmd_q,       cmd_d;
  logic [REGA_BITS-1:0]   addr_q,      addr_d;
  logic [REGD_BITS-1:0]   wdata_q,     wdata_d;
  logic                   wr_pend_q,   wr_pend_d;
  logic                   write_q,     write_d;
  logic                   load_pend_q, load_pend_d;
  logic [REGD_BITS-1:0]   shift_out_q, shift_out_d;
  logic                   miso_q,      miso_d;

  // Received word including the bit being sampled this cycle.
  logic [31:0] frame_word;
  assign frame_word = {shift_in_q, mosi_sync_q};

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      cmd_q       <= 8'hFF;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_pend_q   <= 1'b0;
      write_q     <= 1'b0;
      load_pend_q <= 1'b0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_pend_q   <= wr_pend_d;
      write_q     <= write_d;
      load_pend_q <= load_pend_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_pend_d   = 1'b0;
    // The strobe trails the data register by one cycle so the bank sees
    // stable WRITE_DATA_OUT for the whole pulse.
    write_d     = wr_pend_q;
    load_pend_d = 1'b0;
    shift_out_d = shift_out_q;
    miso_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (nss_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end

      ST_CMD: begin
        if (sclk_rise) begin
          shift_in_d = frame_word[30:0];
          if (bit_cnt_q == 5'd7) begin
            cmd_d     = frame_word[7:0];
            bit_cnt_d = '0;
            state_d   = ST_ADDR;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_ADDR: begin
        if (sclk_rise) begin
          shift_in_d = frame_word[30:0];
          if (bit_cnt_q == 5'd15) begin
            // Upper address bits beyond REGA_BITS are discarded.
            addr_d      = frame_word[REGA_BITS-1:0];
            bit_cnt_d   = '0;
            state_d     = ST_DATA;
            // Capture read data one cycle later, once the bank has seen the
            // new address.
            load_pend_d = (cmd_q == CMD_READ);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (cmd_q == CMD_READ) begin
          miso_d = miso_q;
          if (sclk_fall) begin
            // Zero fill means MISO naturally returns to 0 after bit 0.
            miso_d      = shift_out_q[REGD_BITS-1];
            shift_out_d = {shift_out_q[REGD_BITS-2:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          shift_in_d = frame_word[30:0];
          if (bit_cnt_q == 5'd31) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
            if (cmd_q == CMD_WRITE) begin
              wdata_d   = frame_word[REGD_BITS-1:0];
              wr_pend_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_DONE: begin
        // Surplus SCLK edges are ignored; only NSS high (below) leaves here.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_pend_q) begin
      shift_out_d = READ_DATA_IN;
    end

    // NSS high in any active state ends the frame. A truncated write never
    // reaches the DATA completion branch, so no strobe is raised, and the
    // address/data registers simply keep whatever they last held.
    if ((state_q != ST_IDLE) && nss_sync_q) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end
  end

  assign SPI_MISO_OUT   = miso_q;
  assign WRITE_OUT      = write_q;
  assign ADDR_OUT       = addr_q;
  assign WRITE_DATA_OUT = wdata_q;

endmodule
